qsfp_sb_scan_multi: RTL and testbench

QSFP_SB_SCAN_MULTI -- requirements
Module: qsfp_sb_scan_multi

---
 rtl/qsfp_sb_scan_multi.sv | 226 ++++++++++++++++++++++
 tb/tb_qsfp_sb_scan_multi.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qsfp_sb_scan_multi.sv
// Sideband scanner for a bank of QSFP cages behind an I2C mux: per port it selects the
// mux channel, then either initialises the IO expander or reads MODPRSTL and enables/resets.
module qsfp_sb_scan_multi #(
    parameter int          NUM_PORTS    = 2,
    parameter logic [7:0]  MUX_DEV_ID   = 8'hE0,
    parameter logic [7:0]  SB_DEV_ID    = 8'h40,
    parameter logic [15:0] DELAY_CYCLES = 16'h0400,
    parameter logic [15:0] CMD_TIMEOUT  = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 init,
    output logic                 complete,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] port_present,
    output logic [NUM_PORTS-1:0] port_event,
    output logic [NUM_PORTS-1:0] port_err,
    output logic [7:0]           dbg_cstate,
    output logic                 IO_CONTROL_PULSE,
    output logic                 IO_CONTROL_RW,
    output logic [7:0]           IO_CONTROL_ID,
    output logic [7:0]           IO_ADDR_ADDR,
    output logic [7:0]           IO_WDATA_WDATA,
    input  logic [7:0]           IO_RDATA_RDATA,
    input  logic                 IO_CONTROL_CMPLT
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_DELAY  = 3'd3,
        S_DECIDE = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_MUX = 3'd0,
        OP_OUT = 3'd1,
        OP_CFG = 3'd2,
        OP_RD  = 3'd3,
        OP_RST = 3'd4,
        OP_EN  = 3'd5
    } op_t;

    state_t                state, state_nxt;
    op_t                   op, op_nxt;
    logic [PW-1:0]         p, p_nxt;
    logic                  init_q;
    logic [15:0]           dcnt;
    logic [15:0]           tcnt;
    logic [7:0]            rdata;
    logic [7:0]            mux_sel;
    logic                  op_rw;
    logic [7:0]            op_id, op_addr, op_wdata;
    logic                  timeout, pres, p_last;
    logic [NUM_PORTS-1:0]  present_nxt, err_nxt;
    logic                  rdata_unused;

    assign busy         = (state != S_IDLE);
    assign complete     = (state == S_DONE);
    assign dbg_cstate   = {5'd0, state};
    assign mux_sel      = 8'd1 << p;
    // Only MODPRSTL (bit 2, active low) matters for presence.
    assign pres         = ~rdata[2];
    assign rdata_unused = ^{rdata[7:3], rdata[1:0]};
    assign p_last       = (p == PW'(NUM_PORTS - 1));
    assign timeout      = (state == S_WAIT) && !IO_CONTROL_CMPLT &&
                          (tcnt >= CMD_TIMEOUT - 16'd1);

    always_comb begin
        op_rw    = 1'b0;
        op_id    = SB_DEV_ID;
        op_addr  = 8'h00;
        op_wdata = 8'h00;
        case (op)
            OP_MUX: begin
                op_id    = MUX_DEV_ID;
                op_addr  = mux_sel;
                op_wdata = mux_sel;
            end
            OP_OUT, OP_RST: op_addr = 8'h01;
            OP_CFG: begin
                op_addr  = 8'h03;
                op_wdata = 8'h06;
            end
            OP_RD:  op_rw = 1'b1;
            OP_EN: begin
                op_addr  = 8'h01;
                op_wdata = 8'h10;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        op_nxt      = op;
        p_nxt       = p;
        present_nxt = port_present;
        err_nxt     = port_err;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ISSUE;
                    op_nxt    = OP_MUX;
                    p_nxt     = '0;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                if (op == OP_MUX) err_nxt[p] = 1'b0;
            end
            S_WAIT: begin
                if (IO_CONTROL_CMPLT) begin
                    state_nxt = S_DELAY;
                end else if (timeout) begin
                    // Abandon the rest of this port's sequence; presence is left as-is.
                    err_nxt[p] = 1'b1;
                    state_nxt  = S_NEXT;
                end
            end
            S_DELAY: begin
                if (dcnt == 16'd0) begin
                    case (op)
                        OP_MUX: begin
                            op_nxt    = init_q ? OP_OUT : OP_RD;
                            state_nxt = S_ISSUE;
                        end
                        OP_OUT: begin
                            op_nxt    = OP_CFG;
                            state_nxt = S_ISSUE;
                        end
                        OP_CFG: begin
                            // Forget presence so the following scan re-enables every module.
                            present_nxt[p] = 1'b0;
                            state_nxt      = S_NEXT;
                        end
                        OP_RD:   state_nxt = S_DECIDE;
                        default: state_nxt = S_NEXT;
                    endcase
                end
            end
            S_DECIDE: begin
                present_nxt[p] = pres;
                if (pres && !port_present[p]) begin
                    op_nxt    = OP_EN;
                    state_nxt = S_ISSUE;
                end else if (!pres && port_present[p]) begin
                    op_nxt    = OP_RST;
                    state_nxt = S_ISSUE;
                end else begin
                    state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                if (p_last) begin
                    state_nxt = S_DONE;
                end else begin
                    op_nxt    = OP_MUX;
                    p_nxt     = p + PW'(1);
                    state_nxt = S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            op               <= OP_MUX;
            p                <= '0;
            init_q           <= 1'b0;
            dcnt             <= 16'd0;
            tcnt             <= 16'd0;
            rdata            <= 8'h00;
            port_present     <= '0;
            port_event       <= '0;
            port_err         <= '0;
            IO_CONTROL_PULSE <= 1'b0;
            IO_CONTROL_RW    <= 1'b0;
            IO_CONTROL_ID    <= 8'h00;
            IO_ADDR_ADDR     <= 8'h00;
            IO_WDATA_WDATA   <= 8'h00;
        end else begin
            state        <= state_nxt;
            op           <= op_nxt;
            p            <= p_nxt;
            port_present <= present_nxt;
            port_event   <= present_nxt ^ port_present;
            port_err     <= err_nxt;

            if (state == S_IDLE && start) init_q <= init;

            IO_CONTROL_PULSE <= (state == S_ISSUE);
            if (state == S_ISSUE) begin
                IO_CONTROL_RW  <= op_rw;
                IO_CONTROL_ID  <= op_id;
                IO_ADDR_ADDR   <= op_addr;
                IO_WDATA_WDATA <= op_wdata;
            end else if (state == S_DONE) begin
                IO_CONTROL_RW  <= 1'b0;
                IO_CONTROL_ID  <= 8'h00;
                IO_ADDR_ADDR   <= 8'h00;
                IO_WDATA_WDATA <= 8'h00;
            end

            if (state == S_ISSUE)      tcnt <= 16'd0;
            else if (state == S_WAIT)  tcnt <= tcnt + 16'd1;

            if (state == S_WAIT && IO_CONTROL_CMPLT) begin
                dcnt <= DELAY_CYCLES;
                if (op == OP_RD) rdata <= IO_RDATA_RDATA;
            end else if (state == S_DELAY && dcnt != 16'd0) begin
                dcnt <= dcnt - 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qsfp_sb_scan_multi.sv
// Scoreboard bench for qsfp_sb_scan_multi: expected I2C commands are queued per pass and a
// negedge monitor pops/compares every IO_CONTROL_PULSE; a responder returns CMPLT 3 cycles later.
module tb_qsfp_sb_scan_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       init = 1'b0;
    logic       complete, busy;
    logic [1:0] port_present, port_event, port_err;
    logic [7:0] dbg_cstate;
    logic       io_pulse, io_rw;
    logic [7:0] io_id, io_addr, io_wdata;
    logic [7:0] io_rdata = 8'h00;
    logic       io_cmplt = 1'b0;

    int          checks = 0;
    int          errors = 0;
    logic [24:0] exp_q[$];
    int          pulse_cyc[$];
    int          cyc = 0;
    int          cmp_cnt = 0;
    int          ev_cnt0 = 0;
    int          ev_cnt1 = 0;
    logic [1:0]  ev_prev = 2'b00;
    logic [7:0]  rd_val[2];
    logic [1:0]  withhold = 2'b00;
    logic        late_req = 1'b0;
    logic        late_done = 1'b0;

    always #5 clk = ~clk;

    qsfp_sb_scan_multi #(
        .NUM_PORTS   (2),
        .MUX_DEV_ID  (8'hE0),
        .SB_DEV_ID   (8'h40),
        .DELAY_CYCLES(16'd4),
        .CMD_TIMEOUT (16'd16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .init            (init),
        .complete        (complete),
        .busy            (busy),
        .port_present    (port_present),
        .port_event      (port_event),
        .port_err        (port_err),
        .dbg_cstate      (dbg_cstate),
        .IO_CONTROL_PULSE(io_pulse),
        .IO_CONTROL_RW   (io_rw),
        .IO_CONTROL_ID   (io_id),
        .IO_ADDR_ADDR    (io_addr),
        .IO_WDATA_WDATA  (io_wdata),
        .IO_RDATA_RDATA  (io_rdata),
        .IO_CONTROL_CMPLT(io_cmplt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pops, complete count, port_event pulse width.
    always @(negedge clk) begin
        cyc++;
        if (io_pulse) begin
            pulse_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cmd actual=%0h required=none", {io_rw, io_id, io_addr, io_wdata});
            end else begin
                check("cmd", {7'd0, io_rw, io_id, io_addr, io_wdata}, {7'd0, exp_q.pop_front()});
            end
        end
        if (complete) cmp_cnt++;
        if (port_event != 2'b00) check("event_one_cycle", {30'd0, port_event & ev_prev}, 32'd0);
        ev_cnt0 += int'(port_event[0]);
        ev_cnt1 += int'(port_event[1]);
        ev_prev = port_event;
    end

    // Responder: CMPLT seen by the DUT on the 3rd edge after the PULSE cycle begins.
    initial begin : responder
        int port;
        port = 0;
        forever begin
            @(posedge clk); #1;
            if (late_req && !late_done) begin
                io_cmplt = 1'b1;
                @(posedge clk); #1;
                io_cmplt  = 1'b0;
                late_done = 1'b1;
            end else if (io_pulse) begin
                if (io_id == 8'hE0) port = io_addr[1] ? 1 : 0;
                if (!withhold[port]) begin
                    repeat (2) @(posedge clk);
                    #1;
                    io_cmplt = 1'b1;
                    io_rdata = rd_val[port];
                    @(posedge clk); #1;
                    io_cmplt = 1'b0;
                    io_rdata = 8'h00;
                end
            end
        end
    end

    task automatic push_cmd(input logic r, input logic [7:0] i, input logic [7:0] a, input logic [7:0] w);
        exp_q.push_back({r, i, a, w});
    endtask

    task automatic push_mux(input int pt);
        logic [7:0] s;
        s = 8'd1 << pt;
        push_cmd(1'b0, 8'hE0, s, s);
    endtask

    task automatic push_init_port(input int pt);
        push_mux(pt);
        push_cmd(1'b0, 8'h40, 8'h01, 8'h00);
        push_cmd(1'b0, 8'h40, 8'h03, 8'h06);
    endtask

    task automatic push_rd();
        push_cmd(1'b1, 8'h40, 8'h00, 8'h00);
    endtask

    task automatic check_gap(input int base, input int exp);
        if (pulse_cyc.size() > base + 1) check("pulse_gap", pulse_cyc[base+1] - pulse_cyc[base], exp);
        else check("pulse_gap_count", pulse_cyc.size() - base, 2);
    endtask

    task automatic run_pass(input logic mode, input bit chk_err);
        int base_c;
        bit got;
        bit seen;
        base_c = cmp_cnt;
        got    = 1'b0;
        seen   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        init  = mode;
        @(negedge clk);
        start = 1'b0;
        init  = 1'b0;
        if (chk_err) begin
            for (int i = 0; i < 20; i++) begin
                if (io_pulse) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("first_pulse_seen", seen, 1);
            if (seen) check("err_clear_on_mux", port_err, 0);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (complete) begin
                got = 1'b1;
                break;
            end
        end
        check("pass_complete", got, 1);
        repeat (3) @(negedge clk);
        check("complete_once", cmp_cnt - base_c, 1);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : stim
        int pb, e0, e1, base_c;
        bit got;
        rd_val[0] = 8'hFF;
        rd_val[1] = 8'hFF;

        // Reset and idle behaviour
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_state", dbg_cstate, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_present", port_present, 0);
        check("rst_err", port_err, 0);
        check("rst_pulse", io_pulse, 0);
        check("rst_id", io_id, 0);
        check("rst_complete", complete, 0);
        repeat (10) @(negedge clk);
        check("idle_no_cmd", pulse_cyc.size(), 0);

        // Init pass
        pb = pulse_cyc.size();
        e0 = ev_cnt0;
        push_init_port(0);
        push_init_port(1);
        run_pass(1'b1, 1'b0);
        check("init_present", port_present, 2'b00);
        check_gap(pb, 9);
        check("init_no_event", ev_cnt0 - e0, 0);
        check("init_id_zeroed", io_id, 0);

        // Scan: port 0 present, port 1 empty -> enable port 0
        rd_val[0] = 8'hFB;
        rd_val[1] = 8'hFF;
        e0 = ev_cnt0;
        e1 = ev_cnt1;
        push_mux(0); push_rd(); push_cmd(1'b0, 8'h40, 8'h01, 8'h10);
        push_mux(1); push_rd();
        run_pass(1'b0, 1'b0);
        check("scan_en_present", port_present, 2'b01);
        check("scan_en_event0", ev_cnt0 - e0, 1);
        check("scan_en_event1", ev_cnt1 - e1, 0);

        // Scan: port 0 removed -> reset write
        rd_val[0] = 8'hFF;
        e0 = ev_cnt0;
        push_mux(0); push_rd(); push_cmd(1'b0, 8'h40, 8'h01, 8'h00);
        push_mux(1); push_rd();
        run_pass(1'b0, 1'b0);
        check("scan_rst_present", port_present, 2'b00);
        check("scan_rst_event0", ev_cnt0 - e0, 1);

        // Re-insert port 0
        rd_val[0] = 8'hFB;
        push_mux(0); push_rd(); push_cmd(1'b0, 8'h40, 8'h01, 8'h10);
        push_mux(1); push_rd();
        run_pass(1'b0, 1'b0);
        check("reinsert_present", port_present, 2'b01);

        // Timeout on port 0: MUX abandoned, port 1 still scanned
        withhold = 2'b01;
        pb = pulse_cyc.size();
        push_mux(0);
        push_mux(1); push_rd();
        run_pass(1'b0, 1'b0);
        check("timeout_err", port_err, 2'b01);
        check("timeout_present_kept", port_present, 2'b01);
        check_gap(pb, 18);
        withhold = 2'b00;

        // Init pass clears err on MUX issue and present on CFG completion
        e0 = ev_cnt0;
        push_init_port(0);
        push_init_port(1);
        run_pass(1'b1, 1'b1);
        check("reinit_present", port_present, 2'b00);
        check("reinit_event0", ev_cnt0 - e0, 1);
        check("reinit_err", port_err, 2'b00);

        // start held high throughout a pass
        rd_val[0] = 8'hFB;
        base_c = cmp_cnt;
        got = 1'b0;
        push_mux(0); push_rd(); push_cmd(1'b0, 8'h40, 8'h01, 8'h10);
        push_mux(1); push_rd();
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (complete) begin
                got = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check("held_pass_complete", got, 1);
        check("held_idle", busy, 0);
        repeat (20) @(negedge clk);
        check("held_one_complete", cmp_cnt - base_c, 1);
        check("held_queue_drained", exp_q.size(), 0);
        check("held_present", port_present, 2'b01);

        // Reset during WAIT, then a late CMPLT
        withhold = 2'b01;
        base_c = cmp_cnt;
        got = 1'b0;
        push_mux(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (io_pulse) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_wait_pulse_seen", got, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        late_req = 1'b1;
        pb = pulse_cyc.size();
        repeat (25) @(negedge clk);
        check("late_cmplt_driven", late_done, 1);
        check("midrst_state", dbg_cstate, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_present", port_present, 2'b00);
        check("midrst_err", port_err, 2'b00);
        check("midrst_io", {io_rw, io_id, io_addr, io_wdata}, 0);
        check("midrst_no_pulse", pulse_cyc.size() - pb, 0);
        check("midrst_no_complete", cmp_cnt - base_c, 0);
        check("midrst_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
